// File: rtl/apb_slave.sv
// ---------------------------------------------------------------------------
// apb_slave
//   Zero-wait-state APB slave in front of a 256 x 32-bit register memory.
//   Every transfer takes two edges: SETUP, then ENABLE. There is no pready
//   and no pslverr. Malformed transfers are dropped so memory stays intact.
//
// Ports
//   clk      in   1   rising-edge clock
//   rst_n    in   1   asynchronous active-low reset (FSM and prdata only)
//   paddr    in   8   word address, used directly as the memory index
//   pwrite   in   1   1 = write, 0 = read
//   psel     in   1   slave select
//   penable  in   1   ENABLE-phase strobe
//   pwdata   in  32   write data, taken in the ENABLE cycle
//   prdata   out 32   registered read data, loaded on the read SETUP edge
// ---------------------------------------------------------------------------
module apb_slave (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  paddr,
    input  logic        pwrite,
    input  logic        psel,
    input  logic        penable,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        W_ENABLE = 2'd1,
        R_ENABLE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [31:0] mem [0:255];

    // A SETUP only counts when the slave is idle. An ENABLE seen while idle
    // has no preceding SETUP and is ignored.
    logic setup_ok;
    logic rd_setup;
    logic wr_commit;

    assign setup_ok  = (state == IDLE) && psel && !penable;
    assign rd_setup  = setup_ok && !pwrite;
    // The write direction is re-checked in ENABLE, so a transfer whose
    // direction flips between phases never touches memory.
    assign wr_commit = (state == W_ENABLE) && psel && penable && pwrite;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE: begin
                if (setup_ok) state_nxt = pwrite ? W_ENABLE : R_ENABLE;
                else          state_nxt = IDLE;
            end
            W_ENABLE: state_nxt = IDLE;
            R_ENABLE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Memory has no reset so contents survive it. A write pending when reset
    // hits is lost because the FSM is forced out of W_ENABLE asynchronously.
    always_ff @(posedge clk) begin
        if (wr_commit) mem[paddr] <= pwdata;
    end

    // Read data is captured on the SETUP edge, so it is already stable before
    // the ENABLE edge. It holds until the next read SETUP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        prdata <= 32'h0;
        else if (rd_setup) prdata <= mem[paddr];
    end

endmodule

// File: tb/tb_apb_slave.sv
module tb_apb_slave;

    logic        clk;
    logic        rst_n;
    logic [7:0]  paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] pwdata;
    logic [31:0] prdata;

    apb_slave dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .paddr   (paddr),
        .pwrite  (pwrite),
        .psel    (psel),
        .penable (penable),
        .pwdata  (pwdata),
        .prdata  (prdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: a plain word array plus the queue of read results
    // the monitor should see.
    logic [31:0] model_mem [256];
    logic [31:0] exp_q [$];
    logic [31:0] last_rd;
    logic        mon_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one sample per cycle, 1 time unit after the rising edge.
    // A read SETUP edge produces a new value popped from the scoreboard.
    // Every other cycle prdata has to hold the last read value.
    initial last_rd = 32'h0;
    always @(posedge clk) begin
        logic take;
        take = mon_rd;
        #1;
        if (!rst_n) begin
            last_rd = 32'h0;
            chk("prdata_in_reset", prdata, 32'h0);
        end else if (take) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL read_underflow: got %08h expected none", prdata);
            end else begin
                last_rd = exp_q.pop_front();
                chk("read_data", prdata, last_rd);
            end
        end else begin
            chk("prdata_hold", prdata, last_rd);
        end
    end

    // ---------------- bus phases (driven on the falling edge) ----------------
    task automatic ph_setup(input logic sel, input logic w, input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        psel = sel; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        mon_rd = sel && !w;
        if (sel && !w) exp_q.push_back(model_mem[a]);
    endtask

    task automatic ph_enable(input logic w, input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        psel = 1'b1; penable = 1'b1; pwrite = w; paddr = a; pwdata = d;
        mon_rd = 1'b0;
    endtask

    task automatic ph_idle(input int n);
        repeat (n) begin
            @(negedge clk);
            psel = 1'b0; penable = 1'b0; pwrite = 1'b0; mon_rd = 1'b0;
        end
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        ph_setup(1'b1, 1'b1, a, d);
        ph_enable(1'b1, a, d);
        model_mem[a] = d;
    endtask

    task automatic apb_read(input logic [7:0] a);
        ph_setup(1'b1, 1'b0, a, 32'h0);
        ph_enable(1'b0, a, 32'h0);
    endtask

    // SETUP with psel low followed by a lone write ENABLE: both ignored.
    task automatic bad_nosel(input logic [7:0] a, input logic [31:0] d);
        ph_setup(1'b0, 1'b1, a, d);
        ph_enable(1'b1, a, d);
    endtask

    // Read SETUP then a write ENABLE: counts as a read, never writes.
    task automatic bad_flip(input logic [7:0] a, input logic [31:0] d);
        ph_setup(1'b1, 1'b0, a, d);
        ph_enable(1'b1, a, d);
    endtask

    // ENABLE from IDLE with no SETUP: ignored.
    task automatic bad_lone_enable(input logic [7:0] a, input logic [31:0] d);
        ph_enable(1'b1, a, d);
    endtask

    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 8'h0; pwdata = 32'h0; mon_rd = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ph_idle(1);

        // Give every location a known value.
        for (int i = 0; i < 256; i++) apb_write(8'(i), $urandom);
        ph_idle(1);

        // Basic write, idle, read.
        apb_write(8'h32, 32'h61);
        ph_idle(1);
        apb_read(8'h32);
        ph_idle(1);

        // Hold: prdata keeps 0x61 across a write and idle cycles.
        apb_write(8'h40, 32'hDEAD_BEEF);
        ph_idle(4);

        // SETUP without psel.
        apb_write(8'h00, 32'hFFFF_FFFF);
        bad_nosel(8'h00, 32'hFF);
        apb_read(8'h00);
        ph_idle(1);

        // Direction flip between SETUP and ENABLE.
        apb_write(8'h10, 32'h99);
        bad_flip(8'h10, 32'hFF);
        apb_read(8'h10);
        ph_idle(1);

        // Back-to-back with address wrap.
        apb_write(8'hFE, 32'h31);
        apb_write(8'hFF, 32'h32);
        apb_read(8'hFE);
        apb_read(8'hFF);
        a = 8'hFF;
        a = a + 8'd1;
        apb_write(a, 32'h1234_5678);
        apb_read(8'h00);
        ph_idle(1);

        // Reset during a write ENABLE: no write, prdata cleared at once.
        apb_write(8'h55, 32'hA5A5_0001);
        ph_setup(1'b1, 1'b1, 8'h55, 32'hBAD0_BAD0);
        @(negedge clk);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; mon_rd = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("prdata_async_reset", prdata, 32'h0);
        ph_idle(8);
        rst_n = 1'b1;
        ph_idle(1);
        apb_read(8'h55);
        apb_read(8'h32);
        ph_idle(1);

        // Randomized mix of legal and malformed transfers.
        for (int n = 0; n < 400; n++) begin
            a = 8'($urandom);
            d = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2: apb_write(a, d);
                3, 4, 5: apb_read(a);
                6:       bad_nosel(a, d);
                7:       bad_flip(a, d);
                8:       bad_lone_enable(a, d);
                default: ph_idle($urandom_range(1, 3));
            endcase
        end
        ph_idle(3);

        // Final sweep: every location matches the model.
        for (int i = 0; i < 256; i++) apb_read(8'(i));
        ph_idle(3);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
